// File: rtl/ccd_pattern_source.sv
// Camera-side test pattern transmitter: drives the same fval/dval/X/Y/RGB stream as
// the CCD capture path so the processing pipeline can run without a sensor.
module ccd_pattern_source #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 64
) (
  input  logic        CCD_PIXCLK,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iContinuous,
  input  logic [1:0]  iPattern,
  output logic        oFval,
  output logic        oDval,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [11:0] oCCD_R,
  output logic [11:0] oCCD_G,
  output logic [11:0] oCCD_B,
  output logic        oFrameDone,
  output logic [15:0] oFrameCount,
  output logic        oBusy
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LINE, S_HBLANK, S_VBLANK} state_t;

  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d, bar_cnt_q, bar_cnt_d, fcnt_q, fcnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  pat_q, pat_d;
  logic        fval_q, fval_d, dval_q, dval_d, done_q, done_d, busy_q, busy_d;
  logic [11:0] r_q, r_d, g_q, g_d, b_q, b_d;

  function automatic logic [11:0] chan(input logic on);
    chan = on ? 12'hFF0 : 12'h000;
  endfunction

  // Bar order white, yellow, cyan, green, magenta, red, blue, black as {R,G,B} enables.
  function automatic logic [35:0] pixel(input logic [1:0] pat, input logic [7:0] x,
                                        input logic [7:0] y, input logic [2:0] bar);
    logic [2:0] m;
    case (bar)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    case (pat)
      2'd0:    pixel = {3{x, 4'h0}};
      2'd1:    pixel = {chan(m[2]), chan(m[1]), chan(m[0])};
      2'd2:    pixel = {3{chan(x[4] ^ y[4])}};
      default: pixel = {3{y, 4'h0}};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    fcnt_d    = fcnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (iStart) begin
          pat_d   = iPattern;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        state_d   = S_LINE;
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end
      S_LINE: begin
        if (x_q == X_LAST) begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q == Y_LAST) begin
            state_d = S_VBLANK;
            y_d     = '0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
          end else begin
            state_d = S_HBLANK;
          end
        end else begin
          x_d = x_q + 16'd1;
          // Bar index advances by counting pixels within a bar, avoiding a divider.
          if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d   = S_LINE;
          y_d       = y_q + 16'd1;
          cnt_d     = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (iContinuous) begin
            state_d   = S_LINE;
            pat_d     = iPattern;
            bar_cnt_d = '0;
            bar_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fval_d = (state_d == S_LINE) || (state_d == S_HBLANK);
    dval_d = (state_d == S_LINE);
    busy_d = (state_d != S_IDLE);
    {r_d, g_d, b_d} = dval_d ? pixel(pat_d, x_d[7:0], y_d[7:0], bar_idx_d) : 36'd0;
  end

  always_ff @(posedge CCD_PIXCLK) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      fcnt_q    <= '0;
      fval_q    <= 1'b0;
      dval_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      fcnt_q    <= fcnt_d;
      fval_q    <= fval_d;
      dval_q    <= dval_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign oFval       = fval_q;
  assign oDval       = dval_q;
  assign oX_Cont     = x_q;
  assign oY_Cont     = y_q;
  assign oCCD_R      = r_q;
  assign oCCD_G      = g_q;
  assign oCCD_B      = b_q;
  assign oFrameDone  = done_q;
  assign oFrameCount = fcnt_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_ccd_pattern_source.sv
// Scoreboard bench for ccd_pattern_source: a small-frame instance for timing and
// stream checks, a default-size instance for colour-bar and checkerboard spot values.
module tb_ccd_pattern_source;

  typedef struct {
    int x;
    int y;
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance: 8x4 active, 2 hblank, 3 vblank
  logic        rst_s = 1'b0, s_start = 1'b1, s_cont = 1'b0;
  logic [1:0]  s_pat = 2'd1;
  logic        s_fval, s_dval, s_done, s_busy;
  logic [15:0] s_x, s_y, s_fcount;
  logic [11:0] s_r, s_g, s_b;

  ccd_pattern_source #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .V_BLANK(3)) dut_s (
    .CCD_PIXCLK(clk), .iRst_n(rst_s), .iStart(s_start), .iContinuous(s_cont),
    .iPattern(s_pat), .oFval(s_fval), .oDval(s_dval), .oX_Cont(s_x), .oY_Cont(s_y),
    .oCCD_R(s_r), .oCCD_G(s_g), .oCCD_B(s_b), .oFrameDone(s_done),
    .oFrameCount(s_fcount), .oBusy(s_busy));

  // Default-size instance
  logic        rst_d = 1'b0, d_start = 1'b1, d_cont = 1'b0;
  logic [1:0]  d_pat = 2'd1;
  logic        d_fval, d_dval, d_done, d_busy;
  logic [15:0] d_x, d_y, d_fcount;
  logic [11:0] d_r, d_g, d_b;

  ccd_pattern_source dut_d (
    .CCD_PIXCLK(clk), .iRst_n(rst_d), .iStart(d_start), .iContinuous(d_cont),
    .iPattern(d_pat), .oFval(d_fval), .oDval(d_dval), .oX_Cont(d_x), .oY_Cont(d_y),
    .oCCD_R(d_r), .oCCD_G(d_g), .oCCD_B(d_b), .oFrameDone(d_done),
    .oFrameCount(d_fcount), .oBusy(d_busy));

  pix_t q_s[$];
  pix_t q_d[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pix_t model(int pat, int x, int y, int hact);
    pix_t p;
    logic [7:0]  xv, yv;
    logic [23:0] tbl;
    logic [2:0]  m;
    int bar;
    xv  = 8'(x);
    yv  = 8'(y);
    tbl = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    p.x = x;
    p.y = y;
    case (pat)
      0: begin p.r = {xv, 4'h0}; p.g = p.r; p.b = p.r; end
      1: begin
        bar = x / (hact / 8);
        m   = tbl[bar*3 +: 3];
        p.r = m[2] ? 12'hFF0 : 12'h000;
        p.g = m[1] ? 12'hFF0 : 12'h000;
        p.b = m[0] ? 12'hFF0 : 12'h000;
      end
      2: begin p.r = (xv[4] ^ yv[4]) ? 12'hFF0 : 12'h000; p.g = p.r; p.b = p.r; end
      default: begin p.r = {yv, 4'h0}; p.g = p.r; p.b = p.r; end
    endcase
    return p;
  endfunction

  task automatic push_frame(input int pat);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        q_s.push_back(model(pat, x, y, 8));
  endtask

  task automatic push_d(input int x, input int y, input logic [11:0] r,
                        input logic [11:0] g, input logic [11:0] b);
    pix_t p;
    p.x = x; p.y = y; p.r = r; p.g = g; p.b = b;
    q_d.push_back(p);
  endtask

  // Monitors: pop and compare whenever the DUT presents a valid pixel
  always @(negedge clk) begin : mon_s
    pix_t p;
    if (rst_s && s_dval) begin
      if (q_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_unexpected_pixel: got x=%0d y=%0d, expected no pixel", s_x, s_y);
      end else begin
        p = q_s.pop_front();
        chk("s_pixel", {s_x, s_y, s_r, s_g, s_b}, {16'(p.x), 16'(p.y), p.r, p.g, p.b});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_d && d_dval && q_d.size() > 0) begin
      if (q_d[0].x == int'(d_x) && q_d[0].y == int'(d_y)) begin
        chk($sformatf("d_rgb_x%0d_y%0d", d_x, d_y), {d_r, d_g, d_b},
            {q_d[0].r, q_d[0].g, q_d[0].b});
        void'(q_d.pop_front());
      end
    end
  end

  int fval_runs[$], gaps[$], dbursts[$], dgaps[$];
  int done_cnt, idle_low, first_dval, busy0;
  logic [11:0] r_x5;

  // Steps the small instance from the cycle after a start edge until oBusy falls.
  task automatic watch(input int ncyc, input int mode);
    int fr, dr, low, dlow;
    logic pf, pd, pb, seen_f;
    fval_runs.delete(); gaps.delete(); dbursts.delete(); dgaps.delete();
    fr = 0; dr = 0; low = 0; dlow = 0; pf = 0; pd = 0; pb = 1; seen_f = 0;
    done_cnt = 0; idle_low = -1; first_dval = -1; busy0 = 0; r_x5 = 12'hABC;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin s_start = 1'b0; busy0 = int'(s_busy); end
      if (s_fval) begin
        fr++;
        if (!pf && seen_f) gaps.push_back(low);
        low = 0; seen_f = 1;
      end else begin
        if (pf) fval_runs.push_back(fr);
        fr = 0;
        if (seen_f && s_busy) low++;
      end
      if (s_dval) begin
        dr++;
        if (!pd && dlow > 0) dgaps.push_back(dlow);
        dlow = 0;
        if (first_dval < 0) first_dval = cyc;
        if (s_x == 16'd5 && s_y == 16'd0 && r_x5 == 12'hABC) r_x5 = s_r;
      end else begin
        if (pd) dbursts.push_back(dr);
        dr = 0;
        if (s_fval) dlow++;
      end
      if (s_done) done_cnt++;
      if (pb && !s_busy) begin idle_low = low; break; end
      pb = s_busy; pf = s_fval; pd = s_dval;
      if (mode == 1) begin
        if (done_cnt == 1 && s_fval) s_pat = 2'd2;
        if (done_cnt == 2 && s_fval) s_cont = 1'b0;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    // Reset held with start requested
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_s_ctrl", {s_fval, s_dval, s_done, s_busy, s_x, s_y, s_fcount}, 0);
      chk("rst_s_rgb", {s_r, s_g, s_b}, 0);
      chk("rst_d_ctrl", {d_fval, d_dval, d_done, d_busy, d_x, d_y, d_fcount}, 0);
    end
    s_start = 0; d_start = 0; s_pat = 0;
    @(negedge clk);
    rst_s = 1; rst_d = 1;
    @(negedge clk);
    chk("idle_after_rst", {s_busy, s_fval}, 0);

    // Single frame, h-ramp
    push_frame(0);
    s_start = 1;
    watch(200, 0);
    chk("busy_after_start", busy0, 1);
    chk("first_pixel_latency", first_dval, 1);
    chk("dval_burst_count", dbursts.size(), 4);
    foreach (dbursts[i]) chk("dval_burst_len", dbursts[i], 8);
    chk("dval_gap_count", dgaps.size(), 3);
    foreach (dgaps[i]) chk("dval_gap_len", dgaps[i], 2);
    chk("fval_run_count", fval_runs.size(), 1);
    if (fval_runs.size() > 0) chk("fval_run_len", fval_runs[0], 38);
    chk("r_at_x5", r_x5, 12'h050);
    chk("frame_done_pulses", done_cnt, 1);
    chk("frame_count_1", s_fcount, 1);
    chk("idle_after_vblank", idle_low, 3);
    chk("s_queue_empty_1", q_s.size(), 0);

    // Continuous: three frames, pattern switch visible from frame 3
    @(negedge clk); rst_s = 0;
    @(negedge clk); rst_s = 1;
    chk("fcount_cleared", s_fcount, 0);
    s_cont = 1; s_pat = 0;
    push_frame(0); push_frame(0); push_frame(2);
    s_start = 1;
    watch(400, 1);
    chk("cont_fval_runs", fval_runs.size(), 3);
    foreach (fval_runs[i]) chk("cont_fval_len", fval_runs[i], 38);
    chk("cont_gap_count", gaps.size(), 2);
    foreach (gaps[i]) chk("cont_gap_len", gaps[i], 3);
    chk("cont_done_pulses", done_cnt, 3);
    chk("frame_count_3", s_fcount, 3);
    chk("cont_idle", idle_low, 3);
    chk("s_queue_empty_2", q_s.size(), 0);

    // Ignored start during LINE, then reset mid-frame at X=5, Y=2
    s_pat = 0;
    push_frame(0);
    @(negedge clk); s_start = 1;
    @(negedge clk); s_start = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      s_start = s_dval && s_y == 16'd1 && s_x == 16'd3;
      if (s_dval && s_x == 16'd5 && s_y == 16'd2) begin found = 1; break; end
    end
    chk("reach_x5_y2", found, 1);
    chk("fcount_before_rst", s_fcount, 3);
    rst_s = 0; s_start = 0;
    @(negedge clk);
    chk("mid_rst_ctrl", {s_fval, s_dval, s_busy, s_x, s_y, s_fcount}, 0);
    chk("mid_rst_rgb", {s_r, s_g, s_b}, 0);
    q_s.delete();
    rst_s = 1;
    @(negedge clk);
    chk("idle_stays_after_rst", {s_busy, s_fval}, 0);

    // Colour bars at default size, line 0
    push_d(0,   0, 12'hFF0, 12'hFF0, 12'hFF0);
    push_d(100, 0, 12'hFF0, 12'hFF0, 12'h000);
    push_d(199, 0, 12'hFF0, 12'hFF0, 12'h000);
    push_d(200, 0, 12'h000, 12'hFF0, 12'hFF0);
    push_d(799, 0, 12'h000, 12'h000, 12'h000);
    d_pat = 1; d_start = 1;
    @(negedge clk); d_start = 0;
    for (int i = 0; i < 2000 && q_d.size() > 0; i++) @(negedge clk);
    chk("bars_all_seen", q_d.size(), 0);
    q_d.delete();
    rst_d = 0;
    @(negedge clk); rst_d = 1;

    // Checkerboard at default size
    push_d(0,  0,  12'h000, 12'h000, 12'h000);
    push_d(16, 0,  12'hFF0, 12'hFF0, 12'hFF0);
    push_d(16, 16, 12'h000, 12'h000, 12'h000);
    push_d(31, 16, 12'h000, 12'h000, 12'h000);
    d_pat = 2; d_start = 1;
    @(negedge clk); d_start = 0;
    for (int i = 0; i < 20000 && q_d.size() > 0; i++) @(negedge clk);
    chk("checker_all_seen", q_d.size(), 0);
    rst_d = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
